ea_sequencer: RTL

//  PDP-8 effective-address stage, directly upstream of memory_controller.

---
 rtl/ea_sequencer_pkg.sv | 21 ++
 rtl/ea_sequencer.sv | 106 ++++++++++
 2 files changed

// File: rtl/ea_sequencer_pkg.sv
// Shared types and defaults for the PDP-8 effective-address stage.
package ea_sequencer_pkg;

  typedef logic [11:0] word_t;

  typedef enum logic {
    DATA_READ   = 1'b0,
    INSTR_FETCH = 1'b1
  } read_type_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PTR_READ = 2'd1,
    AUTO_INC = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam word_t AUTOINC_LO_DEF = 12'o0010;
  localparam word_t AUTOINC_HI_DEF = 12'o0017;

endpackage

// File: rtl/ea_sequencer.sv
// PDP-8 effective-address sequencer: direct, indirect and auto-index addressing,
// driving memory_controller for pointer reads and auto-index write-backs.
module ea_sequencer
  import ea_sequencer_pkg::*;
#(
  parameter word_t AUTOINC_LO = AUTOINC_LO_DEF,
  parameter word_t AUTOINC_HI = AUTOINC_HI_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] instr,
  input  logic [11:0] pc,
  output logic        busy,
  output logic        done,
  output logic [11:0] eff_addr,
  output logic [11:0] mem_address,
  output logic [11:0] mem_write_data,
  output logic        mem_read_enable,
  output logic        mem_read_type,
  output logic        mem_write_enable,
  input  logic [11:0] mem_read_data
);

  state_e state_q, state_d;
  word_t  base_q, base_d;
  word_t  ptr_q, ptr_d;
  word_t  ea_q, ea_d;
  logic   rd_en, wr_en, done_c;

  function automatic word_t base_addr(input word_t ir, input word_t cur_pc);
    return ir[7] ? {cur_pc[11:7], ir[6:0]} : {5'b0, ir[6:0]};
  endfunction

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    ptr_d          = ptr_q;
    ea_d           = ea_q;
    rd_en          = 1'b0;
    wr_en          = 1'b0;
    done_c         = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d = base_addr(instr, pc);
          if (instr[8]) begin
            state_d = PTR_READ;
          end else begin
            ea_d    = base_addr(instr, pc);
            state_d = DONE;
          end
        end
      end
      PTR_READ: begin
        mem_address = base_q;
        rd_en       = 1'b1;
        if (base_q >= AUTOINC_LO && base_q <= AUTOINC_HI) begin
          ptr_d   = mem_read_data + 12'd1;
          state_d = AUTO_INC;
        end else begin
          ea_d    = mem_read_data;
          state_d = DONE;
        end
      end
      AUTO_INC: begin
        mem_address    = base_q;
        mem_write_data = ptr_q;
        wr_en          = 1'b1;
        ea_d           = ptr_q;
        state_d        = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Enables and done are masked by rst so a reset edge never commits a write
  // or reports a completion for the abandoned operation.
  assign mem_read_enable  = rd_en && !rst;
  assign mem_write_enable = wr_en && !rst;
  assign done             = done_c && !rst;
  assign mem_read_type    = DATA_READ;
  assign busy             = (state_q != IDLE);
  assign eff_addr         = ea_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      ptr_q   <= '0;
      ea_q    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      ptr_q   <= ptr_d;
      ea_q    <= ea_d;
    end
  end

endmodule
